ppu_frame_writer: RTL and testbench

- Sits directly downstream of the PPU pixel pipeline and consumes its 2-bit pixel stream (pixel + valid) and its mode output.
- Maps each pixel through the BGP palette, packs 4 shades per byte and writes them into the 160x144 framebuffer RAM. The VGA scan-out block reads that RAM.
- Tracks line and frame boundaries from PPU mode transitions and signals frame completion.

---
 rtl/ppu_frame_writer.sv | 159 +++++++++++++++
 tb/tb_ppu_frame_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_frame_writer.sv
// Palette-maps the PPU pixel stream, packs four 2-bit shades per byte and writes the framebuffer.
// Optional macro PPU_FB_DBUF_EN: two frame buffers, the displayed one swapped at each frame_done.
module ppu_frame_writer #(
  parameter int H_PIX    = 160,
  parameter int V_LINES  = 144,
  parameter int ADDR_W   = 14,
  parameter int FB_BYTES = H_PIX * V_LINES / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic [1:0]        ppu_mode,
  input  logic              lcd_en,
  input  logic [7:0]        bgp,
  output logic              fb_wr,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              frame_done,
  output logic              fb_disp_sel,
  output logic              err_overflow,
  output logic              err_short
);
  localparam int         LINE_BYTES  = H_PIX / 4;
  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_DRAW   = 2'd3;

  typedef enum logic [2:0] {IDLE, LINE, LINE_DONE, WAIT, VBLANK} state_t;

  state_t            state;
  logic [1:0]        prev_mode;
  logic [7:0]        x;
  logic [7:0]        y;
  logic [1:0]        pack_cnt;
  logic [7:0]        acc;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] buf_offset;

  logic              accept;
  logic              byte_full;
  logic              hblank_entry;
  logic              vblank_entry;
  logic              line_short;
  logic [1:0]        shade;
  logic [7:0]        acc_next;
  logic [7:0]        x_next;
  logic [7:0]        flush_data;
  logic [2:0]        cnt_next;
  logic [ADDR_W-1:0] wr_addr;

  // Next-state view of the packer including this cycle's pixel, so a pixel that
  // coincides with H_BLANK entry is folded in before the line is closed.
  always_comb begin
    accept       = (state == LINE) && px_valid;
    shade        = bgp[{px_in, 1'b0} +: 2];
    acc_next     = accept ? {acc[5:0], shade} : acc;
    cnt_next     = {1'b0, pack_cnt} + (accept ? 3'd1 : 3'd0);
    x_next       = x + (accept ? 8'd1 : 8'd0);
    byte_full    = accept && (pack_cnt == 2'd3);
    hblank_entry = (prev_mode == MODE_DRAW) && (ppu_mode == MODE_HBLANK);
    vblank_entry = (prev_mode != MODE_VBLANK) && (ppu_mode == MODE_VBLANK);
    line_short   = (x_next != 8'(H_PIX));
    // Byte index of the most recently accepted pixel; only used when a write occurs.
    wr_addr      = line_base + ADDR_W'((x_next - 8'd1) >> 2) + buf_offset;
    case (cnt_next)
      3'd1:    flush_data = {acc_next[1:0], 6'b0};
      3'd2:    flush_data = {acc_next[3:0], 4'b0};
      3'd3:    flush_data = {acc_next[5:0], 2'b0};
      default: flush_data = acc_next;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments under a synchronous reset,
  // so later assignments in this block override earlier ones within the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prev_mode    <= MODE_HBLANK;
      x            <= '0;
      y            <= '0;
      pack_cnt     <= '0;
      acc          <= '0;
      line_base    <= '0;
      fb_wr        <= 1'b0;
      fb_addr      <= '0;
      fb_wdata     <= '0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      prev_mode  <= ppu_mode;
      fb_wr      <= 1'b0;
      frame_done <= 1'b0;
      if (!lcd_en) begin
        state     <= IDLE;
        x         <= '0;
        y         <= '0;
        pack_cnt  <= '0;
        line_base <= '0;
      end else if (vblank_entry) begin
        frame_done <= 1'b1;
        state      <= VBLANK;
        x          <= '0;
        y          <= '0;
        pack_cnt   <= '0;
        line_base  <= '0;
      end else begin
        if (accept) begin
          acc      <= acc_next;
          x        <= x_next;
          pack_cnt <= byte_full ? 2'd0 : cnt_next[1:0];
          if (byte_full) begin
            fb_wr    <= 1'b1;
            fb_addr  <= wr_addr;
            fb_wdata <= acc_next;
          end
          if (!line_short) state <= LINE_DONE;
        end
        if (state == LINE_DONE && px_valid) err_overflow <= 1'b1;

        if ((state == LINE || state == LINE_DONE) && hblank_entry) begin
          if (line_short) begin
            err_short <= 1'b1;
            if (!byte_full && cnt_next != 3'd0) begin
              fb_wr    <= 1'b1;
              fb_addr  <= wr_addr;
              fb_wdata <= flush_data;
            end
          end
          x         <= '0;
          pack_cnt  <= '0;
          y         <= y + 8'd1;
          line_base <= line_base + ADDR_W'(LINE_BYTES);
          state     <= WAIT;
        end else if ((state == IDLE || state == WAIT || state == VBLANK) &&
                     ppu_mode == MODE_DRAW && y < 8'(V_LINES)) begin
          state <= LINE;
        end
      end
    end
  end

`ifdef PPU_FB_DBUF_EN
  logic disp_sel;

  always_ff @(posedge clk) begin
    if (rst)                        disp_sel <= 1'b0;
    else if (lcd_en && vblank_entry) disp_sel <= ~disp_sel;
  end

  assign fb_disp_sel = disp_sel;
  assign buf_offset  = disp_sel ? '0 : ADDR_W'(FB_BYTES);
`else
  assign fb_disp_sel = 1'b0;
  assign buf_offset  = '0;
`endif

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Self-checking bench for ppu_frame_writer: a reference packer pushes expected
// framebuffer writes into a queue that a negedge monitor pops and compares.
module tb_ppu_frame_writer;
  localparam int H_PIX    = 160;
  localparam int V_LINES  = 144;
  localparam int ADDR_W   = 14;
  localparam int FB_BYTES = 5760;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        px_in;
  logic              px_valid;
  logic [1:0]        ppu_mode;
  logic              lcd_en;
  logic [7:0]        bgp;
  logic              fb_wr;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_wdata;
  logic              frame_done;
  logic              fb_disp_sel;
  logic              err_overflow;
  logic              err_short;

  always #5 clk = ~clk;

  ppu_frame_writer #(
    .H_PIX(H_PIX), .V_LINES(V_LINES), .ADDR_W(ADDR_W), .FB_BYTES(FB_BYTES)
  ) dut (
    .clk(clk), .rst(rst), .px_in(px_in), .px_valid(px_valid), .ppu_mode(ppu_mode),
    .lcd_en(lcd_en), .bgp(bgp), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .fb_disp_sel(fb_disp_sel), .err_overflow(err_overflow),
    .err_short(err_short)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   wr_count  = 0;
  int   fd_count  = 0;
  int   exp_fd    = 0;
  int   exp_base  = 0;
  int   exp_y     = 0;
  logic exp_sel   = 1'b0;
  logic exp_ovf   = 1'b0;
  logic exp_short = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (fb_wr === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr %0d data %0h expected no write", fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(fb_addr), 32'(e.addr));
        check("wr_data", 32'(fb_wdata), 32'(e.data));
      end
    end
    if (frame_done === 1'b1) fd_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int buf_off();
`ifdef PPU_FB_DBUF_EN
    return exp_sel ? 0 : FB_BYTES;
`else
    return 0;
`endif
  endfunction

  task automatic push_exp(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = ADDR_W'(addr);
    w.data = data;
    exp_q.push_back(w);
  endtask

  // kind 0: i%4, kind 1: constant val, kind 2: (i/3+val)%4.
  task automatic send_line(input int n, input int kind, input int val, input bit hb_with_last);
    logic [7:0] acc = 8'h00;
    int         cnt = 0;
    logic [1:0] p;
    logic [1:0] sh;
    bit         live;
    live = (exp_y < V_LINES);
    ppu_mode = 2'd3;
    tick();
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       p = 2'(i % 4);
        1:       p = 2'(val);
        default: p = 2'((i / 3 + val) % 4);
      endcase
      px_in    = p;
      px_valid = 1'b1;
      if (hb_with_last && i == n - 1) ppu_mode = 2'd0;
      if (live) begin
        if (i < H_PIX) begin
          sh  = 2'((bgp >> (2 * p)) & 8'h03);
          acc = {acc[5:0], sh};
          cnt++;
          if (cnt == 4) begin
            push_exp(exp_base + i / 4 + buf_off(), acc);
            cnt = 0;
          end
        end else begin
          exp_ovf = 1'b1;
        end
      end
      tick();
      if (live && i == 3) check("wr_latency", 32'(fb_wr), 32'd1);
    end
    px_valid = 1'b0;
    ppu_mode = 2'd0;
    tick();
    if (live) begin
      if (n < H_PIX) begin
        exp_short = 1'b1;
        if (cnt != 0) push_exp(exp_base + (n - 1) / 4 + buf_off(), acc << (2 * (4 - cnt)));
      end
      exp_base += H_PIX / 4;
      exp_y++;
    end
    tick();
  endtask

  task automatic end_frame();
    ppu_mode = 2'd1;
    tick();
    exp_fd++;
`ifdef PPU_FB_DBUF_EN
    exp_sel = ~exp_sel;
`endif
    exp_base = 0;
    exp_y    = 0;
    check("disp_sel_at_frame_done", 32'(fb_disp_sel), 32'(exp_sel));
    tick();
    check("frame_done_count", 32'(fd_count), 32'(exp_fd));
    check("frame_done_width", 32'(frame_done), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    px_valid = 1'b0;
    px_in    = 2'd0;
    ppu_mode = 2'd0;
    lcd_en   = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
    exp_base  = 0;
    exp_y     = 0;
    exp_sel   = 1'b0;
    exp_ovf   = 1'b0;
    exp_short = 1'b0;
    tick();
  endtask

  initial begin
    int w0;
    bgp = 8'hE4;
    do_reset();
    check("rst_fb_wr", 32'(fb_wr), 32'd0);
    check("rst_fb_addr", 32'(fb_addr), 32'd0);
    check("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_disp_sel", 32'(fb_disp_sel), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);

    // Palette and packing, then remaps; a short frame still pulses frame_done.
    bgp = 8'hE4; send_line(H_PIX, 0, 0, 1'b0);
    bgp = 8'h1B; send_line(H_PIX, 1, 3, 1'b0);
    bgp = 8'hFF; send_line(H_PIX, 1, 0, 1'b0);
    end_frame();

    // Full frame with varied palettes, then one line beyond the limit.
    w0 = wr_count;
    for (int l = 0; l < V_LINES; l++) begin
      bgp = 8'(l * 37 + 5);
      send_line(H_PIX, 2, l, 1'b0);
    end
    check("full_frame_writes", 32'(wr_count - w0), 32'(FB_BYTES));
    w0 = wr_count;
    send_line(H_PIX, 0, 0, 1'b0);
    check("line_limit_no_write", 32'(wr_count - w0), 32'd0);
    end_frame();
    check("full_frame_err_overflow", 32'(err_overflow), 32'd0);
    check("full_frame_err_short", 32'(err_short), 32'd0);

    // Short line, following line, overflow line, pixel coincident with H_BLANK.
    do_reset();
    bgp = 8'hE4;
    send_line(6, 1, 3, 1'b0);
    check("short_err_short", 32'(err_short), 32'(exp_short));
    check("short_err_overflow", 32'(err_overflow), 32'd0);
    send_line(H_PIX, 0, 0, 1'b0);
    w0 = wr_count;
    send_line(H_PIX + 5, 2, 1, 1'b0);
    check("overflow_writes", 32'(wr_count - w0), 32'(H_PIX / 4));
    check("overflow_err", 32'(err_overflow), 32'(exp_ovf));
    send_line(8, 0, 0, 1'b1);
    end_frame();

    // Display off mid-line: no writes, no frame_done, sticky flags held.
    ppu_mode = 2'd3;
    tick();
    w0 = wr_count;
    for (int i = 0; i < 2; i++) begin
      px_in = 2'(i); px_valid = 1'b1; tick();
    end
    px_valid = 1'b0;
    lcd_en   = 1'b0;
    tick();
    ppu_mode = 2'd1;
    tick();
    tick();
    check("lcd_off_no_write", 32'(wr_count - w0), 32'd0);
    check("lcd_off_no_frame_done", 32'(fd_count), 32'(exp_fd));
    check("lcd_off_err_short_held", 32'(err_short), 32'd1);
    check("lcd_off_err_overflow_held", 32'(err_overflow), 32'd1);
    lcd_en   = 1'b1;
    ppu_mode = 2'd0;
    tick();
    exp_base = 0;
    exp_y    = 0;
    send_line(H_PIX, 0, 0, 1'b0);
    end_frame();

    // Reset mid-line abandons the partial byte and returns the displayed buffer to 0.
    ppu_mode = 2'd3;
    tick();
    for (int i = 0; i < 3; i++) begin
      px_in = 2'd3; px_valid = 1'b1; tick();
    end
    w0 = wr_count;
    do_reset();
    tick();
    check("midline_rst_no_write", 32'(wr_count - w0), 32'd0);
    check("midline_rst_disp_sel", 32'(fb_disp_sel), 32'd0);
    check("midline_rst_err_short", 32'(err_short), 32'd0);
    check("midline_rst_err_overflow", 32'(err_overflow), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
